tri_feeder: RTL and testbench

TRI_FEEDER -- requirements
Module: tri_feeder

---
 rtl/tri_pkg.sv | 14 +
 rtl/tri_cull.sv | 24 ++
 rtl/tri_feeder.sv | 113 +++++++++++
 tb/tb_tri_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// tri_pkg: shared vertex type, coordinate width, table read latency and feeder FSM states.
package tri_pkg;
    localparam int COORD_W = 9;
    localparam int RD_LAT = 2;
    typedef logic [2:0][COORD_W-1:0] vert_t;
    typedef enum logic [2:0] {IDLE, FETCH_TRI, FETCH_V, XFORM, CULL, PRESENT} state_t;

    function automatic logic [COORD_W-1:0] clamp_add(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b,
                                                      input logic [COORD_W:0] lim);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > lim ? lim[COORD_W-1:0] : s[COORD_W-1:0];
    endfunction
endpackage

// File: rtl/tri_cull.sv
// tri_cull: signed doubled-area of a screen triangle; registers a flag when the area is zero or negative.
module tri_cull
    import tri_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  vert_t v1,
    input  vert_t v2,
    input  vert_t v3,
    output logic  culled
);
    logic signed [20:0] dx2, dy2, dx3, dy3, area;

    // 21 bits hold the full product range of 9-bit coordinates without overflow
    assign dx2 = 21'(v2[2]) - 21'(v1[2]);
    assign dy2 = 21'(v2[1]) - 21'(v1[1]);
    assign dx3 = 21'(v3[2]) - 21'(v1[2]);
    assign dy3 = 21'(v3[1]) - 21'(v1[1]);
    assign area = dx2 * dy3 - dx3 * dy2;

    always_ff @(posedge clk or posedge rst)
        if (rst) culled <= 1'b0;
        else culled <= area[20] || area == '0;
endmodule

// File: rtl/tri_feeder.sv
// tri_feeder: walks the triangle table, fetches/offsets/clamps vertices and hands them to a rasterizer.
// Define BACKFACE_CULL_EN to skip back-facing triangles (the last triangle of an object is always presented).
module tri_feeder
    import tri_pkg::*;
#(
    parameter int WIDTH     = 240,
    parameter int HEIGHT    = 240,
    parameter int NUM_TRIS  = 64,
    parameter int NUM_VERTS = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start_in,
    input  logic [8:0]                     x_off_in,
    input  logic [8:0]                     y_off_in,
    output logic [$clog2(NUM_TRIS)-1:0]    tri_addr_out,
    input  logic [3*$clog2(NUM_VERTS)-1:0] tri_data_in,
    output logic [$clog2(NUM_VERTS)-1:0]   vert_addr_out,
    input  logic [26:0]                    vert_data_in,
    output vert_t                          vert1_out,
    output vert_t                          vert2_out,
    output vert_t                          vert3_out,
    output logic                           valid_tri_out,
    output logic                           obj_done_out,
    input  logic                           ready_in,
    output logic                           busy_out
);
    localparam int TW = $clog2(NUM_TRIS);
    localparam int VW = $clog2(NUM_VERTS);
    localparam int LIM_W = COORD_W + 1;
    localparam logic [LIM_W-1:0] XLIM = LIM_W'(WIDTH - 1);
    localparam logic [LIM_W-1:0] YLIM = LIM_W'(HEIGHT - 1);

    state_t state, nxt;
    logic [2:0] step;
    logic [2:0][VW-1:0] tri_idx, idx;
    logic [COORD_W-1:0] x_off, y_off;
    vert_t raw [3];
    vert_t stage [3];
    logic last, culled, skip, xfer;

    assign tri_idx = tri_data_in;
    assign last = tri_addr_out == TW'(NUM_TRIS - 1);
    assign skip = culled && !last;
    assign xfer = state == PRESENT && ready_in && !skip;
    assign busy_out = state != IDLE;
    // i1 is issued straight from the table output the cycle it arrives; i2/i3 from the captured copy
    assign vert_addr_out = state != FETCH_V ? '0 : step == 3'd0 ? tri_idx[2] :
                           step == 3'd1 ? idx[1] : step == 3'd2 ? idx[0] : '0;

`ifdef BACKFACE_CULL_EN
    tri_cull u_cull (.clk(clk_in), .rst(rst_in), .v1(stage[0]), .v2(stage[1]), .v3(stage[2]), .culled(culled));
`else
    assign culled = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start_in ? FETCH_TRI : IDLE;
            FETCH_TRI: nxt = step == 3'(RD_LAT - 1) ? FETCH_V : FETCH_TRI;
            FETCH_V:   nxt = step == 3'(RD_LAT + 2) ? XFORM : FETCH_V;
            XFORM:     nxt = CULL;
            CULL:      nxt = PRESENT;
            PRESENT:   nxt = (skip || ready_in) ? (last ? IDLE : FETCH_TRI) : PRESENT;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            step <= '0;
            tri_addr_out <= '0;
            idx <= '0;
            x_off <= '0;
            y_off <= '0;
            valid_tri_out <= 1'b0;
            obj_done_out <= 1'b0;
            vert1_out <= '0;
            vert2_out <= '0;
            vert3_out <= '0;
            for (int k = 0; k < 3; k++) begin
                raw[k] <= '0;
                stage[k] <= '0;
            end
        end else begin
            step <= nxt != state ? 3'd0 : step + 3'd1;
            valid_tri_out <= xfer;
            obj_done_out <= xfer && last;
            if (state == IDLE && start_in) begin
                x_off <= x_off_in;
                y_off <= y_off_in;
                tri_addr_out <= '0;
            end
            if (state == PRESENT && nxt == FETCH_TRI) tri_addr_out <= tri_addr_out + 1'b1;
            if (state == FETCH_V && step == 3'd0) idx <= tri_idx;
            for (int k = 0; k < 3; k++) begin
                if (state == FETCH_V && step == 3'(RD_LAT + k)) raw[k] <= vert_data_in;
                if (state == XFORM)
                    stage[k] <= {clamp_add(raw[k][2], x_off, XLIM), clamp_add(raw[k][1], y_off, YLIM), raw[k][0]};
            end
            if (xfer) begin
                vert1_out <= stage[0];
                vert2_out <= stage[1];
                vert3_out <= stage[2];
            end
        end
    end
endmodule

// File: tb/tb_tri_feeder.sv
// tb_tri_feeder: table vectors, hand-written corner sequences and randomized passes against a reference model.
module tb_tri_feeder;
    import tri_pkg::*;
    localparam int NT = 2, NV = 16, W = 240, H = 240;
    localparam int CULL_N =
`ifdef BACKFACE_CULL_EN
        1;
`else
        2;
`endif
    typedef struct { vert_t a, b, c; logic done; } xfer_t;
    typedef struct { logic [8:0] x, y, z, xo, yo, ex, ey; } vec_t;

    logic clk = 0, rst = 1, start = 0, ready = 1;
    logic [8:0] x_off = 0, y_off = 0;
    logic [0:0] tri_addr;
    logic [3:0] vert_addr;
    logic [11:0] tri_data = 0, t_d1 = 0;
    logic [26:0] vert_data = 0, v_d1 = 0;
    vert_t v1, v2, v3;
    logic valid, done, busy;
    logic [11:0] tri_mem [NT];
    logic [26:0] vert_mem [NV];
    logic [80:0] prev = 0;
    xfer_t got[$];
    int n_vec = 0, n_bad = 0, n_chg = 0;

    always #5 clk = ~clk;

    tri_feeder #(.WIDTH(W), .HEIGHT(H), .NUM_TRIS(NT), .NUM_VERTS(NV)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .x_off_in(x_off), .y_off_in(y_off),
        .tri_addr_out(tri_addr), .tri_data_in(tri_data), .vert_addr_out(vert_addr), .vert_data_in(vert_data),
        .vert1_out(v1), .vert2_out(v2), .vert3_out(v3), .valid_tri_out(valid), .obj_done_out(done),
        .ready_in(ready), .busy_out(busy)
    );

    // two-cycle synchronous table reads
    always @(posedge clk) begin
        t_d1 <= tri_mem[tri_addr];
        tri_data <= t_d1;
        v_d1 <= vert_mem[vert_addr];
        vert_data <= v_d1;
    end

    always @(negedge clk) begin
        if (valid) got.push_back('{v1, v2, v3, done});
        if (!rst && ((!valid && {v1, v2, v3} != prev) || (done && !valid))) n_chg++;
        prev = {v1, v2, v3};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vert_t xf(input logic [26:0] v, input logic [8:0] xo, input logic [8:0] yo);
        int x = int'(v[26:18]) + int'(xo);
        int y = int'(v[17:9]) + int'(yo);
        if (x > W - 1) x = W - 1;
        if (y > H - 1) y = H - 1;
        return {9'(x), 9'(y), v[8:0]};
    endfunction

    function automatic int area(input vert_t a, input vert_t b, input vert_t c);
        return (int'(b[2]) - int'(a[2])) * (int'(c[1]) - int'(a[1])) - (int'(c[2]) - int'(a[2])) * (int'(b[1]) - int'(a[1]));
    endfunction

    task automatic compare_pass(input logic [8:0] xo, input logic [8:0] yo);
        xfer_t exp[$];
        for (int t = 0; t < NT; t++) begin
            logic [11:0] td = tri_mem[t];
            vert_t a = xf(vert_mem[td[11:8]], xo, yo);
            vert_t b = xf(vert_mem[td[7:4]], xo, yo);
            vert_t c = xf(vert_mem[td[3:0]], xo, yo);
            bit cull = 0;
`ifdef BACKFACE_CULL_EN
            cull = t != NT - 1 && area(a, b, c) <= 0;
`endif
            if (!cull) exp.push_back('{a, b, c, t == NT - 1});
        end
        check("xfer_count", got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("xfer%0d_v1", i), got[i].a, exp[i].a);
            check($sformatf("xfer%0d_v2", i), got[i].b, exp[i].b);
            check($sformatf("xfer%0d_v3", i), got[i].c, exp[i].c);
            check($sformatf("xfer%0d_done", i), got[i].done, exp[i].done);
        end
    endtask

    task automatic start_pass(input logic [8:0] xo, input logic [8:0] yo);
        got.delete();
        @(negedge clk);
        x_off = xo;
        y_off = yo;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic finish_pass(input bit rnd);
        int cyc = 0;
        while (busy && cyc < 600) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("pass_end_busy", busy, 0);
        ready = 1;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_v1"}, v1, 0);
        check({tag, "_v2"}, v2, 0);
        check({tag, "_v3"}, v3, 0);
        check({tag, "_tri_addr"}, tri_addr, 0);
        check({tag, "_vert_addr"}, vert_addr, 0);
    endtask

    // two front-facing triangles (positive area)
    task automatic load_base();
        tri_mem[0] = {4'd1, 4'd2, 4'd3};
        tri_mem[1] = {4'd4, 4'd5, 4'd6};
        vert_mem[1] = {9'd0, 9'd0, 9'd1};
        vert_mem[2] = {9'd10, 9'd0, 9'd2};
        vert_mem[3] = {9'd0, 9'd10, 9'd3};
        vert_mem[4] = {9'd20, 9'd20, 9'd4};
        vert_mem[5] = {9'd30, 9'd20, 9'd5};
        vert_mem[6] = {9'd20, 9'd30, 9'd6};
    endtask

    initial begin
        vec_t tbl[7];
        int lat;
        tbl = '{'{230, 5, 77, 20, 3, 239, 8}, '{0, 0, 0, 0, 0, 0, 0}, '{239, 239, 511, 0, 0, 239, 239},
                '{240, 100, 1, 0, 0, 239, 100}, '{511, 511, 5, 511, 511, 239, 239},
                '{100, 200, 300, 139, 39, 239, 239}, '{10, 20, 30, 5, 6, 15, 26}};
        for (int k = 0; k < NV; k++) vert_mem[k] = 27'(k * 3);
        load_base();
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 0;

        got.delete();
        @(negedge clk);
        x_off = 0;
        y_off = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1 if (valid && lat == 0) lat = e;
        end
        check("latency", lat, 10);
        check("busy_after_obj", busy, 0);
        @(negedge clk);
        check("first_v1", got[0].a, vert_mem[1]);
        check("second_done", got[1].done, 1);
        compare_pass(0, 0);

        for (int i = 0; i < 7; i++) begin
            tri_mem[0] = {4'd1, 4'd2, 4'd3};
            tri_mem[1] = {4'd1, 4'd2, 4'd3};
            vert_mem[1] = {tbl[i].x, tbl[i].y, tbl[i].z};
            start_pass(tbl[i].xo, tbl[i].yo);
            finish_pass(1);
            check($sformatf("tbl%0d_v1", i), got[0].a, {tbl[i].ex, tbl[i].ey, tbl[i].z});
        end

        load_base();
        got.delete();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1 check_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (30) @(negedge clk);
        check("no_valid_after_rst", got.size(), 0);
        check("idle_after_rst", busy, 0);
        start_pass(7, 9);
        finish_pass(0);
        compare_pass(7, 9);

        ready = 0;
        start_pass(5, 6);
        repeat (60) @(negedge clk);
        check("hold_no_valid", got.size(), 0);
        check("hold_v1", v1, xf(vert_mem[4], 7, 9));
        check("hold_v3", v3, xf(vert_mem[6], 7, 9));
        ready = 1;
        @(negedge clk);
        check("hold_valid_pulse", valid, 1);
        check("hold_xfer_v1", v1, xf(vert_mem[1], 5, 6));
        @(negedge clk);
        check("hold_valid_single", valid, 0);
        finish_pass(0);
        compare_pass(5, 6);

        ready = 0;
        start_pass(3, 4);
        repeat (30) @(negedge clk);
        x_off = 100;
        y_off = 100;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        finish_pass(0);
        compare_pass(3, 4);
        repeat (30) @(negedge clk);
        check("no_restart", got.size(), 2);
        check("idle_final", busy, 0);

        // both triangles back-facing: only the last one may appear when culling
        tri_mem[0] = {4'd1, 4'd2, 4'd3};
        tri_mem[1] = {4'd4, 4'd5, 4'd6};
        vert_mem[1] = {9'd0, 9'd0, 9'd0};
        vert_mem[2] = {9'd0, 9'd10, 9'd0};
        vert_mem[3] = {9'd10, 9'd0, 9'd0};
        vert_mem[4] = {9'd20, 9'd20, 9'd0};
        vert_mem[5] = {9'd20, 9'd30, 9'd0};
        vert_mem[6] = {9'd30, 9'd20, 9'd0};
        start_pass(0, 0);
        finish_pass(0);
        compare_pass(0, 0);
        check("cull_count", got.size(), CULL_N);

        for (int r = 0; r < 25; r++) begin
            logic [8:0] xo = 9'($urandom_range(0, 511));
            logic [8:0] yo = 9'($urandom_range(0, 511));
            for (int t = 0; t < NT; t++) tri_mem[t] = 12'($urandom);
            for (int k = 0; k < NV; k++) vert_mem[k] = 27'($urandom);
            start_pass(xo, yo);
            finish_pass(1);
            compare_pass(xo, yo);
        end

        check("outputs_held_between_xfers", n_chg, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
